// File: rtl/io_serial_word_rx.sv
// Pin-side 3-wire serial word receiver with a small word FIFO.
// Oversamples the host link on wb_clk_i and streams words to the core.
module io_serial_word_rx #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       ser_clk_i,
  input  logic                       ser_cs_n_i,
  input  logic                       ser_dat_i,
  output logic                       ser_rdy_o,
  output logic [3:0]                 pin_oeb_o,
  output logic [WORD_W-1:0]          word_o,
  output logic                       word_valid_o,
  input  logic                       word_ready_i,
  output logic                       frame_err_o,
  output logic                       overflow_o,
  input  logic                       err_clr_i,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WORD_W);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WORD_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic cs_s1_q, cs_s2_q;
  logic dat_s1_q, dat_s2_q;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              rdy_q, rdy_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;

  logic              rise, push, frame, full, pop, wr, drop;
  logic [WORD_W-1:0] word_in;

  always_comb begin
    rise    = clk_s2_q & ~clk_s3_q & ~cs_s2_q;
    word_in = {shift_q[WORD_W-2:0], dat_s2_q};
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    frame   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_s2_q) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_s2_q) begin
          state_d = IDLE;
          shift_d = '0;
          cnt_d   = '0;
          frame   = (cnt_q != '0);
        end else if (rise) begin
          shift_d = word_in;
          cnt_d   = cnt_q + CW'(1);
          push    = (cnt_q == CNT_MAX);
        end
      end
      default: state_d = IDLE;
    endcase

    full = (level_q == DEPTH_L);
    pop  = (level_q != '0) & word_ready_i;
    // A pop frees the slot the full-FIFO push lands in.
    wr   = push & (~full | pop);
    drop = push & full & ~pop;

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr) begin
      mem_d[wptr_q] = word_in;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);

    level_d = level_q;
    unique case ({wr, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    rdy_d  = (level_q < DEPTH_L);
    ferr_d = frame | (ferr_q & ~err_clr_i);
    ovf_d  = drop | (ovf_q & ~err_clr_i);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      clk_s1_q <= 1'b0;
      clk_s2_q <= 1'b0;
      clk_s3_q <= 1'b0;
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      dat_s1_q <= 1'b0;
      dat_s2_q <= 1'b0;
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      rdy_q    <= 1'b1;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      clk_s1_q <= ser_clk_i;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      cs_s1_q  <= ser_cs_n_i;
      cs_s2_q  <= cs_s1_q;
      dat_s1_q <= ser_dat_i;
      dat_s2_q <= dat_s1_q;
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign word_o       = mem_q[rptr_q];
  assign word_valid_o = (level_q != '0);
  assign level_o      = level_q;
  assign ser_rdy_o    = rdy_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;
  assign pin_oeb_o    = 4'b0111;

endmodule

// File: tb/tb_io_serial_word_rx.sv
// Scoreboard bench for io_serial_word_rx: host bit-bangs words at clk/8,
// expected words are queued at send time and checked as the core pops them.
module tb_io_serial_word_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ser_clk = 1'b0;
  logic        ser_cs_n = 1'b1;
  logic        ser_dat = 1'b0;
  logic        ser_rdy;
  logic [3:0]  oeb;
  logic [31:0] word;
  logic        valid;
  logic        ready = 1'b0;
  logic        ferr;
  logic        ovf;
  logic        clr = 1'b0;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  io_serial_word_rx #(.DEPTH(4), .WORD_W(32)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .ser_clk_i   (ser_clk),
    .ser_cs_n_i  (ser_cs_n),
    .ser_dat_i   (ser_dat),
    .ser_rdy_o   (ser_rdy),
    .pin_oeb_o   (oeb),
    .word_o      (word),
    .word_valid_o(valid),
    .word_ready_i(ready),
    .frame_err_o (ferr),
    .overflow_o  (ovf),
    .err_clr_i   (clr),
    .level_o     (level)
  );

  always #5 clk = ~clk;

  // Consumer side of the scoreboard: a pop happens at the next posedge.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got %h, expected no word", word);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (word !== e) begin
          n_bad++;
          $display("FAIL pop_word: got %h, expected %h", word, e);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      ser_clk = 1'b0;
      ser_dat = w[31-k];
      wait_cyc(4);
      ser_clk = 1'b1;
      wait_cyc(4);
    end
  endtask

  task automatic cs_low();
    ser_clk = 1'b0;
    ser_cs_n = 1'b0;
    wait_cyc(4);
  endtask

  task automatic cs_high();
    ser_clk = 1'b0;
    wait_cyc(2);
    ser_cs_n = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(2);
    n_cmp++;
    if (oeb !== 4'b0111) begin
      n_bad++;
      $display("FAIL oeb_in_reset: got %b, expected 0111", oeb);
    end
    rst = 1'b0;
    wait_cyc(1);
    n_cmp++;
    if ({valid, word, level, ferr, ovf, ser_rdy, oeb} !==
        {1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 4'b0111}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b w=%h l=%0d fe=%b ov=%b rdy=%b oeb=%b, expected 0 0 0 0 0 1 0111",
               valid, word, level, ferr, ovf, ser_rdy, oeb);
    end
  endtask

  task automatic test_single();
    cs_low();
    exp_q.push_back(32'hDEADBEEF);
    send_bits(32'hDEADBEEF, 32);
    n_cmp++;
    if ({valid, word, level, ferr, ovf} !== {1'b1, 32'hDEADBEEF, 3'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL single_word: got v=%b w=%h l=%0d fe=%b ov=%b, expected 1 deadbeef 1 0 0",
               valid, word, level, ferr, ovf);
    end
    cs_high();
    ready = 1'b1;
    wait_cyc(3);
    ready = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL single_drain: got v=%b left=%0d, expected 0 0", valid, exp_q.size());
    end
  endtask

  task automatic test_burst();
    int t;
    ready = 1'b0;
    cs_low();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) exp_q.push_back(32'(i));
      send_bits(32'(i), 32);
    end
    cs_high();
    n_cmp++;
    if ({level, ser_rdy, ovf, valid, ferr} !== {3'd4, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL burst_full: got l=%0d rdy=%b ov=%b v=%b fe=%b, expected 4 0 1 1 0",
               level, ser_rdy, ovf, valid, ferr);
    end
    ready = 1'b1;
    t = 0;
    while (valid && t < 20) begin
      wait_cyc(1);
      t++;
    end
    wait_cyc(1);
    ready = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || level !== 3'd0 || ser_rdy !== 1'b1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL burst_drain: got v=%b l=%0d rdy=%b left=%0d, expected 0 0 1 0",
               valid, level, ser_rdy, exp_q.size());
    end
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_clr: got ov=%b, expected 0", ovf);
    end
  endtask

  task automatic test_frame_err();
    cs_low();
    send_bits(32'hFFFF_0000, 13);
    cs_high();
    n_cmp++;
    if ({ferr, level, valid} !== {1'b1, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL frame_err: got fe=%b l=%0d v=%b, expected 1 0 0", ferr, level, valid);
    end
    cs_low();
    exp_q.push_back(32'hA5A5A5A5);
    send_bits(32'hA5A5A5A5, 32);
    cs_high();
    n_cmp++;
    if ({valid, word, level, ferr} !== {1'b1, 32'hA5A5A5A5, 3'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL frame_next_word: got v=%b w=%h l=%0d fe=%b, expected 1 a5a5a5a5 1 1",
               valid, word, level, ferr);
    end
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    n_cmp++;
    if (ferr !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_clr: got fe=%b, expected 0", ferr);
    end
    ready = 1'b1;
    wait_cyc(2);
    ready = 1'b0;
  endtask

  // Fill the FIFO, then send a fifth word whose last rise lands while
  // either ready (pop) or err_clr_i is held for exactly that cycle.
  task automatic fill_and_fifth(input logic [31:0] base, input logic use_pop,
                                input logic [31:0] fifth);
    ready = 1'b0;
    cs_low();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(base * 32'(i));
      send_bits(base * 32'(i), 32);
    end
    if (use_pop) exp_q.push_back(fifth);
    send_bits(fifth, 31);
    ser_clk = 1'b0;
    ser_dat = fifth[0];
    wait_cyc(4);
    ser_clk = 1'b1;
    wait_cyc(2);
    if (use_pop) ready = 1'b1;
    else clr = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    clr = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_full_push_pop();
    int t;
    fill_and_fifth(32'h11, 1'b1, 32'h55);
    n_cmp++;
    if ({level, ovf, valid} !== {3'd4, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL full_push_pop: got l=%0d ov=%b v=%b, expected 4 0 1", level, ovf, valid);
    end
    cs_high();
    ready = 1'b1;
    t = 0;
    while (valid && t < 20) begin
      wait_cyc(1);
      t++;
    end
    ready = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL full_push_pop_drain: got v=%b left=%0d, expected 0 0", valid, exp_q.size());
    end
  endtask

  task automatic test_clr_collision();
    int t;
    fill_and_fifth(32'h101, 1'b0, 32'hBAD0BAD0);
    n_cmp++;
    if ({ovf, level} !== {1'b1, 3'd4}) begin
      n_bad++;
      $display("FAIL clr_collision: got ov=%b l=%0d, expected 1 4", ovf, level);
    end
    cs_high();
    ready = 1'b1;
    t = 0;
    while (valid && t < 20) begin
      wait_cyc(1);
      t++;
    end
    ready = 1'b0;
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || ovf !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL clr_collision_drain: got v=%b ov=%b left=%0d, expected 0 0 0",
               valid, ovf, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    cs_low();
    send_bits(32'hCAFE0001, 32);
    send_bits(32'hCAFE0002, 32);
    send_bits(32'hCAFE0003, 20);
    ser_clk = 1'b0;
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    n_cmp++;
    if ({level, valid, ferr, ovf, ser_rdy} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid: got l=%0d v=%b fe=%b ov=%b rdy=%b, expected 0 0 0 0 1",
               level, valid, ferr, ovf, ser_rdy);
    end
    ser_cs_n = 1'b1;
    wait_cyc(6);
    cs_low();
    exp_q.push_back(32'h12345678);
    send_bits(32'h12345678, 32);
    cs_high();
    n_cmp++;
    if ({valid, word, level, ferr} !== {1'b1, 32'h12345678, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_next: got v=%b w=%h l=%0d fe=%b, expected 1 12345678 1 0",
               valid, word, level, ferr);
    end
    ready = 1'b1;
    wait_cyc(2);
    ready = 1'b0;
  endtask

  initial begin
    wait_cyc(1);
    test_reset();
    test_single();
    test_burst();
    test_frame_err();
    test_full_push_pop();
    test_clr_collision();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left: got %0d words pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
